// File: rtl/uart_receiver_fsm.sv
// UART receiver: 2-flop input synchronizer plus an oversampling frame FSM
// that recovers start, 8 data bits (LSB first), parity and stop bits.
module uart_receiver_fsm #(
    parameter int OVS   = 16,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       baud_tick,
    input  logic       PbitEna,
    input  logic       Rxin,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       Rxo
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MID  = CNT_W'(OVS/2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OVS - 1);

    state_t             state;
    logic               rx_m;
    logic               rx_s;
    logic [CNT_W-1:0]   tick_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic               pbit_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= Rxin;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            pbit_err   <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            Rxo        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            Rxo        <= 1'b0;
            if (!ena) begin
                state    <= IDLE;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    // half-bit wait so later samples land on bit midpoints
                    START: begin
                        if (baud_tick) begin
                            if (tick_cnt == MID) begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                state    <= rx_s ? IDLE : DATA;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (baud_tick) begin
                            if (tick_cnt == LAST) begin
                                tick_cnt       <= '0;
                                shreg[bit_cnt] <= rx_s;
                                if (bit_cnt == 3'd7) begin
                                    state <= PARITY;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        if (baud_tick) begin
                            if (tick_cnt == LAST) begin
                                tick_cnt <= '0;
                                pbit_err <= rx_s != (PbitEna ? ^shreg : 1'b1);
                                state    <= STOP;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        if (baud_tick) begin
                            if (tick_cnt == LAST) begin
                                tick_cnt <= '0;
                                if (rx_s) begin
                                    data_out   <= shreg;
                                    parity_err <= pbit_err;
                                    data_valid <= 1'b1;
                                    state      <= IDLE;
                                end else begin
                                    frame_err <= 1'b1;
                                    Rxo       <= 1'b1;
                                    state     <= BREAK;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    // held-low line must return high before a new start is accepted
                    BREAK: begin
                        if (baud_tick && rx_s) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
